// File: rtl/hazard_pkg.sv
// Shared constants for the hazard/bypass scoreboard and the decode logic that
// drives it. Select value 0 means "read the regfile"; any nonzero select k
// means "forward from the slot-k pipeline register" (1 = E ... DEPTH = W).
package hazard_pkg;

  localparam int SEL_RF = 0;

  // Slot index by whose end a result is available.
  localparam int RDY_ALU  = 1;
  localparam int RDY_LOAD = 2;

  // Opcodes decode uses to derive issue_rdy (load/jal/jalr) and src_late (store).
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;

  // Out-of-range readiness (0 or beyond the last slot) means "only at writeback".
  function automatic int norm_rdy(input int rdy, input int depth);
    return (rdy == 0 || rdy > depth) ? depth : rdy;
  endfunction

endpackage

// File: rtl/hazard_src_check.sv
// Per-source hazard check: finds the youngest in-flight writer of this source,
// decides forward-vs-stall from its readiness, and adds the long-latency hit.
module hazard_src_check
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int RW    = 2,
  parameter int SW    = 2
) (
  input  logic                       src_valid,
  input  logic [AW-1:0]              src_addr,
  input  logic                       src_late,
  input  logic [DEPTH-1:0]           slot_vld,
  input  logic [DEPTH-1:0][AW-1:0]   slot_rd,
  input  logic [DEPTH-1:0][RW-1:0]   slot_rdy,
  input  logic                       mc_busy,
  input  logic [AW-1:0]              mc_rd,
  output logic [SW-1:0]              sel,
  output logic                       stall
);

  int hit_k;
  int hit_rdy;
  int t;

  // Youngest match wins: scan oldest to youngest so the lowest slot overwrites.
  always_comb begin
    hit_k   = 0;
    hit_rdy = 0;
    t       = 0;
    sel     = SW'(SEL_RF);
    stall   = 1'b0;
    if (src_valid && src_addr != '0) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (slot_vld[k] && slot_rd[k] == src_addr) begin
          hit_k   = k + 1;
          hit_rdy = int'(slot_rdy[k]);
        end
      end
      if (hit_k == DEPTH) begin
        // Regfile is being written this cycle without write-through.
        stall = 1'b1;
      end else if (hit_k != 0) begin
        t = hit_k + 1;
        if (src_late && hit_k + 2 <= DEPTH) t = t + 1;
        if (hit_rdy <= t - 1) sel = SW'(t);
        else                  stall = 1'b1;
      end
      if (mc_busy && mc_rd == src_addr) stall = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and bypass controller beside decode: tracks in-flight writers over
// DEPTH post-decode slots plus one long-latency unit, and produces per-source
// forwarding selects and a single decode stall.
// Optional: HAZARD_SCOREBOARD_PERF_EN adds a 32-bit stall_cycles counter port.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int AW      = 5,
  parameter int RW      = 2,
  parameter int SW      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic                  issue_wr,
  input  logic [AW-1:0]         issue_rd,
  input  logic [RW-1:0]         issue_rdy,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [NUM_SRC*AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]    src_late,
  input  logic                  flush,
  input  logic                  mc_issue,
  input  logic                  mc_done,
  output logic                  stall,
  output logic [NUM_SRC*SW-1:0] src_sel,
  output logic                  mc_busy
`ifdef HAZARD_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  logic [DEPTH-1:0]           slot_vld_q, slot_vld_d;
  logic [DEPTH-1:0][AW-1:0]   slot_rd_q,  slot_rd_d;
  logic [DEPTH-1:0][RW-1:0]   slot_rdy_q, slot_rdy_d;
  logic                       mc_busy_q,  mc_busy_d;
  logic [AW-1:0]              mc_rd_q,    mc_rd_d;

  logic [NUM_SRC-1:0]         src_stall;
  logic [NUM_SRC-1:0][SW-1:0] src_sel_raw;
  logic                       mc_conflict;
  logic                       slot_load;
  logic                       mc_accept;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_check #(.DEPTH(DEPTH), .AW(AW), .RW(RW), .SW(SW)) u_chk (
      .src_valid (src_valid[i]),
      .src_addr  (src_addr[i*AW +: AW]),
      .src_late  (src_late[i]),
      .slot_vld  (slot_vld_q),
      .slot_rd   (slot_rd_q),
      .slot_rdy  (slot_rdy_q),
      .mc_busy   (mc_busy_q),
      .mc_rd     (mc_rd_q),
      .sel       (src_sel_raw[i]),
      .stall     (src_stall[i])
    );
  end

  // Stall merge; selects are only meaningful when decode actually advances.
  always_comb begin
    mc_conflict = issue_valid && mc_issue && mc_busy_q && !mc_done;
    stall       = (|src_stall) || mc_conflict;
    src_sel     = stall ? '0 : src_sel_raw;
    slot_load   = issue_valid && issue_wr && issue_rd != '0 && !mc_issue && !stall && !flush;
    mc_accept   = issue_valid && mc_issue && !stall && !flush;
  end

  // Next slot state: shift toward W, slot 1 takes the decode writer or a bubble.
  always_comb begin
    slot_vld_d    = '0;
    slot_rd_d     = '0;
    slot_rdy_d    = '0;
    slot_vld_d[0] = slot_load;
    slot_rd_d[0]  = issue_rd;
    slot_rdy_d[0] = RW'(norm_rdy(int'(issue_rdy), DEPTH));
    for (int k = 1; k < DEPTH; k++) begin
      slot_vld_d[k] = slot_vld_q[k-1];
      slot_rd_d[k]  = slot_rd_q[k-1];
      slot_rdy_d[k] = slot_rdy_q[k-1];
    end
  end

  // Long-latency tracker: a new accepted issue overrides a same-cycle completion.
  always_comb begin
    mc_busy_d = mc_busy_q;
    mc_rd_d   = mc_rd_q;
    if (mc_accept) begin
      mc_busy_d = 1'b1;
      mc_rd_d   = issue_rd;
    end else if (mc_done) begin
      mc_busy_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q <= '0;
      slot_rd_q  <= '0;
      slot_rdy_q <= '0;
      mc_busy_q  <= 1'b0;
      mc_rd_q    <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_rd_q  <= slot_rd_d;
      slot_rdy_q <= slot_rdy_d;
      mc_busy_q  <= mc_busy_d;
      mc_rd_q    <= mc_rd_d;
    end
  end

  assign mc_busy = mc_busy_q;

`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count stalled cycles, wrapping naturally at 32 bits.
  always_comb begin
    stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  // Perf counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
